// File: rtl/axi_burst_ram_pkg.sv
// axi_burst_ram_pkg: burst/response encodings, FSM state types and
// small response helpers shared by the burst RAM and its address generator.
package axi_burst_ram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } wstate_e;
  typedef enum logic       { R_IDLE, R_DATA }         rstate_e;

  // Worst response wins; encodings are ordered OKAY < SLVERR < DECERR.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED, INCR
// and WRAP bursts. One instance serves each engine.
module axi_burst_addr_gen
  import axi_burst_ram_pkg::*;
#(
  parameter int AddressWidth = 32
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [7:0]              len,
  input  logic [2:0]              size,
  input  logic [1:0]              burst,
  output logic [AddressWidth-1:0] next_addr
);

  logic [AddressWidth-1:0] step;
  logic [AddressWidth-1:0] incr;
  logic [AddressWidth-1:0] wmask;
  burst_e                  btype;

  assign btype = burst_e'(burst);

  // WRAP keeps the bits above the (len+1)*2^size window and wraps the rest.
  always_comb begin
    step      = AddressWidth'(1) << size;
    incr      = addr + step;
    wmask     = ((AddressWidth'(len) + AddressWidth'(1)) << size) - AddressWidth'(1);
    next_addr = incr;
    case (btype)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wmask) | (incr & wmask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 subordinate byte-addressable RAM with independent
// read and write burst engines (one outstanding burst each).
// Optional macro AXI_BURST_RAM_ERROR_EN enables DECERR/SLVERR reporting;
// without it addresses wrap modulo MemoryBytes and every response is OKAY.
module axi_burst_ram
  import axi_burst_ram_pkg::*;
#(
  parameter int DataWidth          = 32,
  parameter int AddressWidth       = 32,
  parameter int TransactionIdWidth = 4,
  parameter int MemoryBytes        = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  // write address
  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awvalid,
  output logic                          awready,
  // write data
  input  logic [DataWidth-1:0]          wdata,
  input  logic [DataWidth/8-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  // write response
  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  // read address
  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arvalid,
  output logic                          arready,
  // read data
  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int Bpb      = DataWidth / 8;
  localparam int LaneBits = $clog2(Bpb);
  localparam int MemBits  = $clog2(MemoryBytes);
  localparam int NumWords = MemoryBytes / Bpb;
  localparam int WordBits = MemBits - LaneBits;

  typedef struct packed {
    logic [TransactionIdWidth-1:0] id;
    logic [AddressWidth-1:0]       addr;
    logic [7:0]                    len;
    logic [2:0]                    size;
    logic [1:0]                    burst;
  } req_t;

  logic                    rst_done;
  wstate_e                 wstate, wstate_nx;
  rstate_e                 rstate, rstate_nx;
  req_t                    wreq, rreq;
  logic [7:0]              wcnt, rcnt;
  logic [AddressWidth-1:0] wnext, rnext, rd_addr;
  logic                    aw_hs, w_hs, ar_hs, r_hs, w_final;
  logic [1:0]              wresp_q, rresp_q;
  logic [DataWidth-1:0]    rdata_q, rd_word;
  logic                    rlast_q;
  logic [1:0]              aw_resp, w_beat_resp, rd_resp;
  logic                    w_keep, rd_zero;
  logic [WordBits-1:0]     w_widx, r_widx;

`ifdef AXI_BURST_RAM_ERROR_EN
  function automatic logic oob(input logic [AddressWidth-1:0] a);
    return a >= AddressWidth'(MemoryBytes);
  endfunction

  function automatic logic [1:0] req_err(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
    logic [1:0] e;
    e = RESP_OKAY;
    if (32'(size) > LaneBits) e = RESP_SLVERR;
    if (burst_e'(burst) == BURST_WRAP && !wrap_len_ok(len)) e = RESP_SLVERR;
    return e;
  endfunction
`endif

  // Address generators: one per engine, fed by the latched request.
  axi_burst_addr_gen #(.AddressWidth(AddressWidth)) u_wgen (
    .addr(wreq.addr), .len(wreq.len), .size(wreq.size), .burst(wreq.burst), .next_addr(wnext)
  );
  axi_burst_addr_gen #(.AddressWidth(AddressWidth)) u_rgen (
    .addr(rreq.addr), .len(rreq.len), .size(rreq.size), .burst(rreq.burst), .next_addr(rnext)
  );

  // The read port looks at the AR address while idle, else at the next beat.
  assign rd_addr = (rstate == R_IDLE) ? araddr : rnext;
  assign w_widx  = wreq.addr[MemBits-1:LaneBits];
  assign r_widx  = rd_addr[MemBits-1:LaneBits];
  assign w_final = (wcnt == wreq.len);

  // Ready outputs stay low until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  // Per-beat response codes and write suppression.
  always_comb begin
    aw_resp     = RESP_OKAY;
    w_beat_resp = RESP_OKAY;
    w_keep      = 1'b1;
    rd_resp     = RESP_OKAY;
    rd_zero     = 1'b0;
`ifdef AXI_BURST_RAM_ERROR_EN
    aw_resp = req_err(awsize, awburst, awlen);
    if (oob(wreq.addr)) begin
      w_beat_resp = RESP_DECERR;
      w_keep      = 1'b0;
    end
    if (wlast != w_final) w_beat_resp = resp_merge(w_beat_resp, RESP_SLVERR);
    if (rstate == R_IDLE) begin
      rd_resp = req_err(arsize, arburst, arlen);
      rd_zero = oob(araddr);
    end else begin
      rd_resp = req_err(rreq.size, rreq.burst, rreq.len);
      rd_zero = oob(rnext);
    end
    if (rd_zero) rd_resp = resp_merge(rd_resp, RESP_DECERR);
`endif
  end

  // Write FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wstate_nx;
  end

  // Write FSM next state, handshakes and channel readies.
  always_comb begin
    wstate_nx = wstate;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (wstate)
      W_IDLE: begin
        awready = rst_done;
        aw_hs   = awvalid && rst_done;
        if (aw_hs) wstate_nx = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        w_hs   = wvalid;
        if (w_hs && w_final) wstate_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  // Write request latch, beat counter and response accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wreq    <= '0;
      wcnt    <= '0;
      wresp_q <= RESP_OKAY;
    end else if (aw_hs) begin
      wreq    <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
      wcnt    <= '0;
      wresp_q <= aw_resp;
    end else if (w_hs) begin
      wreq.addr <= wnext;
      wcnt      <= wcnt + 8'd1;
      wresp_q   <= resp_merge(wresp_q, w_beat_resp);
    end
  end

  // Memory: one byte bank per lane so each strobe bit is an independent
  // write enable. Banks are not reset; reads are asynchronous and get
  // registered into rdata, so a same-cycle write is seen only afterwards.
  for (genvar b = 0; b < Bpb; b++) begin : g_lane
    logic [7:0] bank [NumWords];

    // Strobed byte write for this lane.
    always_ff @(posedge clk) begin
      if (w_hs && w_keep && wstrb[b]) bank[w_widx] <= wdata[b*8 +: 8];
    end

    assign rd_word[b*8 +: 8] = bank[r_widx];
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rstate_nx;
  end

  // Read FSM next state, handshakes and channel valids.
  always_comb begin
    rstate_nx = rstate;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (rstate)
      R_IDLE: begin
        arready = rst_done;
        ar_hs   = arvalid && rst_done;
        if (ar_hs) rstate_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        r_hs   = rready;
        if (r_hs && rlast_q) rstate_nx = R_IDLE;
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  // Read request latch and registered beat (data, last, response).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rreq    <= '0;
      rcnt    <= '0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rreq    <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
      rcnt    <= '0;
      rdata_q <= rd_zero ? '0 : rd_word;
      rlast_q <= (arlen == 8'd0);
      rresp_q <= rd_resp;
    end else if (r_hs) begin
      if (rlast_q) begin
        rlast_q <= 1'b0;
      end else begin
        rreq.addr <= rnext;
        rcnt      <= rcnt + 8'd1;
        rdata_q   <= rd_zero ? '0 : rd_word;
        rlast_q   <= ((rcnt + 8'd1) == rreq.len);
        rresp_q   <= rd_resp;
      end
    end
  end

  assign bid   = wreq.id;
  assign bresp = wresp_q;
  assign rid   = rreq.id;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rlast_q;

  // Upper address bits only matter when range checking is built in.
  logic unused_bits;
  assign unused_bits = ^{wlast, wreq.addr, rd_addr};

endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: randomized burst traffic against a byte-array model
// of the RAM, plus directed INCR/WRAP/FIXED, stall, range and reset cases.
`timescale 1ns/1ps
module tb_axi_burst_ram;

  localparam int MEMB  = 4096;
  localparam int FIXED = 0;
  localparam int INCR  = 1;
  localparam int WRAP  = 2;
`ifdef AXI_BURST_RAM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mm [MEMB];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_q [$];

  axi_burst_ram dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Address of beat i from the burst rules.
  function automatic int beat_addr(int st, int len, int size, int burst, int i);
    int step, win, base;
    step = 1 << size;
    win  = (len + 1) * step;
    base = st - (st % win);
    case (burst)
      FIXED:   return st;
      WRAP:    return base + ((st - base + i * step) % win);
      default: return st + i * step;
    endcase
  endfunction

  function automatic logic [1:0] mx(logic [1:0] a, logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] exp_err(int size, int burst, int len, int a);
    logic [1:0] e;
    e = 2'd0;
    if (ERR_EN && size > 2) e = 2'd2;
    if (ERR_EN && burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 2'd2;
    if (ERR_EN && a >= MEMB) e = 2'd3;
    return e;
  endfunction

  function automatic logic [31:0] mword(int a);
    int w;
    w = (a % MEMB) & ~3;
    if (ERR_EN && a >= MEMB) return 32'd0;
    return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
  endfunction

  task automatic axi_wr(input logic [3:0] id, input int addr, input int len, input int size,
                        input int burst, input bit gaps);
    int n, a, w;
    logic [1:0] er;
    awid = id; awaddr = 32'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    chk("awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    er = 2'd0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      chk("wready", 32'(wready), 32'd1);
      tick();
      a  = beat_addr(addr, len, size, burst, i);
      er = mx(er, exp_err(size, burst, len, a));
      w  = (a % MEMB) & ~3;
      if (!(ERR_EN && a >= MEMB))
        for (int b = 0; b < 4; b++) if (ws[i][b]) mm[w+b] = wd[i][8*b +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_lat", 32'(bvalid), 32'd1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 32'(er));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done", 32'(bvalid), 32'd0);
  endtask

  // mode 0: rready held high, 1: toggled every other cycle, 2: random.
  task automatic axi_rd(input logic [3:0] id, input int addr, input int len, input int size,
                        input int burst, input int mode);
    int n, i, a;
    bit rr;
    logic [31:0] hold;
    rd_q.delete();
    arid = id; araddr = 32'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    chk("arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_lat", 32'(rvalid), 32'd1);
    i = 0; n = 0; hold = '0;
    while (i <= len && n < 4 * (len + 1) + 20) begin
      rr = (mode == 0) || (mode == 1 && n % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
      rready = rr;
      chk("rvalid", 32'(rvalid), 32'd1);
      if (rr) begin
        a = beat_addr(addr, len, size, burst, i);
        chk("rdata", rdata, mword(a));
        chk("rlast", 32'(rlast), 32'(i == len));
        chk("rid", 32'(rid), 32'(id));
        chk("rresp", 32'(rresp), 32'(exp_err(size, burst, len, a)));
        rd_q.push_back(rdata);
        i++;
      end else begin
        hold = rdata;
      end
      tick();
      n++;
      if (!rr) chk("r_stable", rdata, hold);
    end
    rready = 1'b0;
    chk("r_end", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int n, bt, sz, ln, ad, a, lanes, off, mask;
    reset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    for (int k = 0; k < MEMB; k++) mm[k] = '0;
    repeat (3) tick();
    chk("rst_ctl", 32'({awready, arready, wready, bvalid, rvalid, rlast}), 32'd0);
    chk("rst_ids", 32'({bresp, rresp, bid, rid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("aw_pre", 32'(awready), 32'd0);
    tick();
    chk("aw_up", 32'({awready, arready}), 32'h3);

    // Fill the whole array so the model and DUT start identical.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_wr(4'(blk), blk * 1024, 255, 2, INCR, 1'b0);
    end

    // INCR write then read back.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * 32'(i + 1); ws[i] = 4'hF; end
    axi_wr(4'h5, 'h100, 3, 2, INCR, 1'b0);
    axi_rd(4'h6, 'h100, 3, 2, INCR, 0);
    for (int i = 0; i < 4; i++) chk("incr_rd", rd_q[i], 32'h11 * 32'(i + 1));

    // WRAP: 0x108, 0x10C, 0x100, 0x104.
    axi_rd(4'h7, 'h108, 3, 2, WRAP, 0);
    for (int i = 0; i < 4; i++) chk("wrap_rd", rd_q[i], 32'h11 * 32'(((i + 2) % 4) + 1));

    // FIXED strobed bytes into one word.
    wd[0] = '0; ws[0] = 4'hF;
    axi_wr(4'h1, 'h200, 0, 2, INCR, 1'b0);
    wd[0] = 32'h0000_00AA; ws[0] = 4'h1;
    wd[1] = 32'h0000_BB00; ws[1] = 4'h2;
    wd[2] = 32'h00CC_0000; ws[2] = 4'h4;
    axi_wr(4'h2, 'h200, 2, 2, FIXED, 1'b0);
    axi_rd(4'h3, 'h200, 0, 2, INCR, 0);
    chk("fixed_rd", rd_q[0], 32'h00CC_BBAA);

    // rready toggling on an 8-beat read.
    axi_rd(4'h9, 'h300, 7, 2, INCR, 1);
    chk("toggle_cnt", 32'(rd_q.size()), 32'd8);

    // Write beyond the array.
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    axi_wr(4'h4, 'h000, 0, 2, INCR, 1'b0);
    wd[0] = 32'hDEAD_BEEF;
    axi_wr(4'h8, 'h2000, 0, 2, INCR, 1'b0);
    axi_rd(4'hC, 'h000, 0, 2, INCR, 0);
    chk("oob_word", rd_q[0], ERR_EN ? 32'h1234_5678 : 32'hDEAD_BEEF);

    // Reset during beat 2 of a 4-beat read.
    arid = 4'hA; araddr = 32'h400; arlen = 8'd3; arsize = 3'd2; arburst = 2'(INCR);
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    tick();
    chk("mid_beat2", rdata, mword('h408));
    reset = 1'b1;
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    chk("mid_arready", 32'(arready), 32'd0);
    rready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rel_arready", 32'(arready), 32'd1);
    axi_rd(4'hB, 'h400, 3, 2, INCR, 0);

    // Random bursts, written then read back with random back-pressure.
    for (int k = 0; k < 25; k++) begin
      bt = $urandom_range(0, 2);
      sz = $urandom_range(0, 2);
      ln = (bt == WRAP) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      ad = $urandom_range(0, MEMB - 128) & ~((1 << sz) - 1);
      lanes = 1 << sz;
      for (int i = 0; i <= ln; i++) begin
        a     = beat_addr(ad, ln, sz, bt, i);
        off   = a & 3 & ~(lanes - 1);
        mask  = ((1 << lanes) - 1) << off;
        wd[i] = $urandom;
        ws[i] = 4'($urandom & mask);
      end
      axi_wr(4'($urandom), ad, ln, sz, bt, 1'b1);
      axi_rd(4'($urandom), ad, ln, sz, bt, 2);
      axi_rd(4'($urandom), $urandom_range(0, MEMB - 64) & ~3, $urandom_range(0, 15), 2, INCR, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram.md
# axi_burst_ram

AXI4 subordinate memory that answers burst traffic from an AXI4 manager such as the FastVDMA data ports, so a DMA engine can be exercised without forwarding every data beat to Renode. It serves independent read and write channels with FIXED, INCR and WRAP bursts and per-transaction IDs. Memory is a flat byte-addressable array. It sits on the data-side AXI bus in place of, or beside, the Renode-backed subordinate.

## Interface
Parameters:
- `DataWidth`, 32: data bus width in bits; 32 or 64.
- `AddressWidth`, 32: `awaddr`/`araddr` width.
- `TransactionIdWidth`, 4: width of the ID signals.
- `MemoryBytes`, 4096: array size; power of two, multiple of `DataWidth/8`.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `awid`/`awaddr`/`awlen`[8]/`awsize`[3]/`awburst`[2]/`awvalid` in; `awready` out.
- `wdata`/`wstrb`[DataWidth/8]/`wlast`/`wvalid` in; `wready` out.
- `bid`/`bresp`[2]/`bvalid` out; `bready` in.
- `arid`/`araddr`/`arlen`[8]/`arsize`[3]/`arburst`[2]/`arvalid` in; `arready` out.
- `rid`/`rdata`/`rresp`[2]/`rlast`/`rvalid` out; `rready` in.

## Operation
- Read and write engines are independent. Each engine holds at most one outstanding burst.
- Write FSM: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: `awready`=1. On AW handshake, latch id, address, length, size and burst, then go to W_DATA.
  - W_DATA: `wready`=1. Each handshake writes bytes where `wstrb`=1, then advances the address. After beat `awlen+1`, go to W_RESP.
  - W_RESP: `bvalid`=1 until `bready`, then return to W_IDLE.
- Read FSM: R_IDLE, R_DATA.
  - R_IDLE: `arready`=1. On AR handshake, latch the request, go to R_DATA, and register beat 0.
  - R_DATA: `rvalid`=1. On `rready`, present the next beat in the following cycle. `rlast`=1 on beat `arlen`. After the last handshake, return to R_IDLE.
- Address generation:
  - FIXED: address is constant.
  - INCR: add `2^size` per beat.
  - WRAP: wrap within an aligned `(len+1)*2^size` window.
- Narrow transfers place data on the lane selected by the address low bits; `rdata` returns the full aligned word.
- The array is not reset.
- A read and a write to the same word in the same cycle: the read returns the old data.
- `reset` mid-burst abandons both bursts. Array writes already performed persist.

## Timing
- Reset values: `awready`=0, `arready`=0, `wready`=0, `bvalid`=0, `rvalid`=0, `rlast`=0, `bresp`=0, `rresp`=0, `bid`=0, `rid`=0, `rdata`=0.
- `awready` and `arready` assert on the first edge after `reset` deasserts.
- Write latency: `bvalid` asserts the cycle after the last W handshake.
- Read latency: `rvalid` asserts the cycle after the AR handshake.
- Throughput: with `rready` and `wvalid` held high, one beat per cycle.
- Handshakes: `valid` and payload hold stable until `ready`. No output depends combinationally on a `valid` or `ready` input.

## Configuration
- Macro `AXI_BURST_RAM_ERROR_EN`.
- Defined:
  - Address beyond `MemoryBytes` gives DECERR. Such writes are suppressed; such reads return 0.
  - `awsize`/`arsize` wider than the bus gives SLVERR.
  - WRAP with length not in {2,4,8,16} gives SLVERR.
  - `wlast` not matching the final beat gives SLVERR.
  - An erroring burst still completes its full beat count.
- Undefined: address is taken modulo `MemoryBytes`, all responses are OKAY, and `wlast` is ignored.

## Structure
- Package `axi_burst_ram_pkg` holds:
  - burst type enum (FIXED=0, INCR=1, WRAP=2);
  - response constants (OKAY=0, SLVERR=2, DECERR=3);
  - write and read FSM state enums.
- Sub-module `axi_burst_addr_gen`: combinational next-address calculation for all three burst types. It is instantiated once per engine.

## Test plan
- INCR write at 0x100, `awlen`=3, size 2, data 0x11..0x44 → BRESP OKAY with matching `bid`. Read back `arlen`=3 → four beats 0x11..0x44, `rlast` only on beat 3.
- WRAP read at 0x108, `arlen`=3, size 2 → addresses 0x108, 0x10C, 0x100, 0x104.
- FIXED write at 0x200, 3 beats, `wstrb`=0x1, 0x2, 0x4, bytes AA/BB/CC → word at 0x200 reads 0x00CCBBAA.
- `rready` toggled every other cycle on an 8-beat read → no beat lost or repeated; `rdata` stable while stalled.
- With `AXI_BURST_RAM_ERROR_EN`: write to 0x2000 (beyond 4 KiB) → `bresp`=3 and memory unchanged. Without the macro: the same write lands at 0x000 with OKAY.
- Assert `reset` during beat 2 of a 4-beat read → `rvalid`=0 immediately; a fresh read after release succeeds.
